// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } dmem_state_e;

    localparam int unsigned STORE_BIT    = 3;
    localparam int unsigned UNSIGNED_BIT = 2;
    localparam logic [1:0]  SIZE_B       = 2'b01;
    localparam logic [1:0]  SIZE_H       = 2'b10;
    localparam logic [1:0]  SIZE_W       = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_TMO_W          = 8;

    typedef struct packed {
        logic [29:0] word_addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Response timeout counter: expired_o rises in the TIMEOUT_CYCLES-th enabled cycle after clear.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // Expiry is registered one count ahead so the FSM sees it in the final RSP cycle.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clear_i) begin
            cnt_d     = '0;
            expired_d = (TIMEOUT_CYCLES == 1);
        end else if (en_i && !expired_q) begin
            cnt_d     = cnt_q + TMO_W'(1);
            expired_d = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory bus controller: stalls the pipeline across one valid/ready request + response.
// Optional misaligned-access trap enabled by DMEM_MISALIGN_CHECK_EN.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TMO_W          = DEFAULT_TMO_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic [3:0]  sl_type_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        access_fault_o,
    output logic        misalign_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic [31:0] bus_req_addr_o,
    output logic        bus_req_we_o,
    output logic [3:0]  bus_req_wstrb_o,
    output logic [31:0] bus_req_wdata_o,
    input  logic        bus_rsp_valid_i,
    input  logic [31:0] bus_rsp_rdata_i,
    input  logic        bus_rsp_err_i
);

    dmem_state_e state_q, state_d;
    dmem_req_t   req_q, req_d;
    logic        load_q, load_d;
    logic        drop_q, drop_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        access_fault_q, access_fault_d;
    logic        misalign_q, misalign_d;

    logic        take_c;
    logic        misalign_c;
    logic        drop_nxt_c;
    logic        cnt_clear_c;
    logic        cnt_en_c;
    logic        expired;
    logic        unused_c;

    assign take_c = mem_req_i && !flush_i && (sl_type_i[1:0] != 2'b00);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_c = is_misaligned(sl_type_i[1:0], addr_i[1:0]);
    assign unused_c   = sl_type_i[UNSIGNED_BIT];
`else
    assign misalign_c = 1'b0;
    assign unused_c   = ^{sl_type_i[UNSIGNED_BIT], addr_i[1:0]};
`endif

    dmem_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear_c),
        .en_i      (cnt_en_c),
        .expired_o (expired)
    );

    // Next-state, request capture and one-cycle DONE pulses.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        load_d         = load_q;
        drop_d         = drop_q;
        rdata_d        = rdata_q;
        rdata_valid_d  = 1'b0;
        access_fault_d = 1'b0;
        misalign_d     = 1'b0;
        stall_o        = 1'b0;
        cnt_clear_c    = 1'b0;
        cnt_en_c       = 1'b0;
        drop_nxt_c     = drop_q | flush_i;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (take_c) begin
                    stall_o = 1'b1;
                    load_d  = !sl_type_i[STORE_BIT];
                    if (misalign_c) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        req_d.word_addr = addr_i[31:2];
                        req_d.we        = sl_type_i[STORE_BIT];
                        req_d.wstrb     = sl_type_i[STORE_BIT] ? wstrb_i : 4'b0000;
                        req_d.wdata     = wdata_i;
                        state_d         = REQ;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                // A handshake in the flush cycle is already on the bus, so its response must be drained.
                if (bus_req_ready_i) begin
                    cnt_clear_c = 1'b1;
                    drop_d      = flush_i;
                    state_d     = RSP;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            RSP: begin
                stall_o  = 1'b1;
                cnt_en_c = 1'b1;
                drop_d   = drop_nxt_c;
                if (bus_rsp_valid_i) begin
                    if (load_q) begin
                        rdata_d = bus_rsp_rdata_i;
                    end
                    rdata_valid_d  = load_q && !drop_nxt_c;
                    access_fault_d = bus_rsp_err_i && !drop_nxt_c;
                    state_d        = DONE;
                end else if (expired) begin
                    rdata_valid_d  = load_q && !drop_nxt_c;
                    access_fault_d = !drop_nxt_c;
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            req_q          <= '0;
            load_q         <= 1'b0;
            drop_q         <= 1'b0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            access_fault_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            load_q         <= load_d;
            drop_q         <= drop_d;
            rdata_q        <= rdata_d;
            rdata_valid_q  <= rdata_valid_d;
            access_fault_q <= access_fault_d;
            misalign_q     <= misalign_d;
        end
    end

    assign bus_req_valid_o = (state_q == REQ);
    assign bus_req_addr_o  = {req_q.word_addr, 2'b00};
    assign bus_req_we_o    = req_q.we;
    assign bus_req_wstrb_o = req_q.wstrb;
    assign bus_req_wdata_o = req_q.wdata;
    assign rdata_o         = rdata_q;
    assign rdata_valid_o   = rdata_valid_q;
    assign access_fault_o  = access_fault_q;
    assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed scenarios plus randomized transactions vs. a transaction-level model.
module tb_dmem_bus_ctrl;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic [3:0]  sl_type_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        access_fault_o;
    logic        misalign_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic [31:0] bus_req_addr_o;
    logic        bus_req_we_o;
    logic [3:0]  bus_req_wstrb_o;
    logic [31:0] bus_req_wdata_o;
    logic        bus_rsp_valid_i;
    logic [31:0] bus_rsp_rdata_i;
    logic        bus_rsp_err_i;

    int ntests = 0;
    int nfail  = 0;

    dmem_bus_ctrl #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_i       (mem_req_i),
        .sl_type_i       (sl_type_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .wstrb_i         (wstrb_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .rdata_o         (rdata_o),
        .rdata_valid_o   (rdata_valid_o),
        .access_fault_o  (access_fault_o),
        .misalign_o      (misalign_o),
        .bus_req_valid_o (bus_req_valid_o),
        .bus_req_ready_i (bus_req_ready_i),
        .bus_req_addr_o  (bus_req_addr_o),
        .bus_req_we_o    (bus_req_we_o),
        .bus_req_wstrb_o (bus_req_wstrb_o),
        .bus_req_wdata_o (bus_req_wdata_o),
        .bus_rsp_valid_i (bus_rsp_valid_i),
        .bus_rsp_rdata_i (bus_rsp_rdata_i),
        .bus_rsp_err_i   (bus_rsp_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        chk1({tag, " stall"},  stall_o, 1'b0);
        chk1({tag, " valid"},  bus_req_valid_o, 1'b0);
        chk1({tag, " rvalid"}, rdata_valid_o, 1'b0);
        chk1({tag, " fault"},  access_fault_o, 1'b0);
        chk1({tag, " misal"},  misalign_o, 1'b0);
    endtask

    // One full transaction; expected behaviour derived from the access description alone.
    task automatic run_txn(input string tag, input logic [3:0] slt, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int rdy_dly, input int rsp_dly, input logic err,
                           input logic [31:0] rd, input bit timeout, input bit flush_rsp);
        logic        is_load;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        int          n_rsp;
        is_load  = !slt[3];
        exp_addr = {addr[31:2], 2'b00};
        exp_strb = is_load ? 4'b0000 : wstrb;
        n_rsp    = timeout ? int'(TMO) : rsp_dly + 1;

        mem_req_i = 1'b1; sl_type_i = slt; addr_i = addr; wdata_i = wdata; wstrb_i = wstrb; flush_i = 1'b0;
        #1;
        chk1({tag, " detect stall"}, stall_o, 1'b1);
        chk1({tag, " detect novalid"}, bus_req_valid_o, 1'b0);
        tick();
        addr_i = $urandom; wdata_i = $urandom; wstrb_i = 4'($urandom);
        for (int i = 0; i <= rdy_dly; i++) begin
            bus_req_ready_i = (i == rdy_dly);
            #1;
            chk1 ({tag, " req valid"}, bus_req_valid_o, 1'b1);
            chk32({tag, " req addr"},  bus_req_addr_o, exp_addr);
            chk1 ({tag, " req we"},    bus_req_we_o, slt[3]);
            chk32({tag, " req wstrb"}, 32'(bus_req_wstrb_o), 32'(exp_strb));
            chk32({tag, " req wdata"}, bus_req_wdata_o, wdata);
            chk1 ({tag, " req stall"}, stall_o, 1'b1);
            tick();
        end
        bus_req_ready_i = 1'b0;
        for (int j = 0; j < n_rsp; j++) begin
            bus_rsp_valid_i = !timeout && (j == rsp_dly);
            bus_rsp_err_i   = err;
            bus_rsp_rdata_i = (j == rsp_dly) ? rd : 32'h0BAD_0BAD;
            flush_i         = flush_rsp && (j == 0);
            #1;
            chk1({tag, " rsp stall"},   stall_o, 1'b1);
            chk1({tag, " rsp novalid"}, bus_req_valid_o, 1'b0);
            chk1({tag, " rsp norvalid"}, rdata_valid_o, 1'b0);
            tick();
        end
        bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; flush_i = 1'b0;
        #1;
        chk1({tag, " done stall"},  stall_o, 1'b0);
        chk1({tag, " done rvalid"}, rdata_valid_o, is_load && !flush_rsp);
        chk1({tag, " done fault"},  access_fault_o, (err || timeout) && !flush_rsp);
        chk1({tag, " done misal"},  misalign_o, 1'b0);
        if (is_load && !flush_rsp && !timeout)
            chk32({tag, " done rdata"}, rdata_o, rd);
        mem_req_i = 1'b0;
        tick();
        check_quiet({tag, " after"});
        if (is_load && !flush_rsp && !timeout)
            chk32({tag, " rdata hold"}, rdata_o, rd);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1; mem_req_i = 1'b0; sl_type_i = 4'h0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
        flush_i = 1'b0; bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0; bus_rsp_err_i = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        chk32("reset rdata", rdata_o, 32'h0);
        chk32("reset addr",  bus_req_addr_o, 32'h0);
        rst = 1'b0;
        tick();

        // LW, immediate ready and response
        run_txn("lw", 4'b0011, 32'h100, 32'h0, 4'hF, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        // SB with 4-cycle delayed ready
        run_txn("sb", 4'b1001, 32'h203, 32'h55000000, 4'b1000, 4, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        // LW with bus error
        run_txn("lw err", 4'b0011, 32'h40, 32'h0, 4'hF, 1, 2, 1'b1, 32'h12345678, 1'b0, 1'b0);
        // LW timeout, then a late response is ignored
        run_txn("lw tmo", 4'b0011, 32'h80, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
        bus_rsp_valid_i = 1'b1; bus_rsp_err_i = 1'b1; bus_rsp_rdata_i = 32'hFFFF_FFFF;
        tick();
        bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0;
        tick();
        check_quiet("late rsp");
        // Flush during RSP with an error response: consumed, no pulses
        run_txn("lw flush rsp", 4'b0011, 32'hC0, 32'h0, 4'hF, 0, 1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);

        // Flush during REQ before ready
        mem_req_i = 1'b1; sl_type_i = 4'b0011; addr_i = 32'h300; flush_i = 1'b0;
        tick();
        #1;
        chk1("flush req valid", bus_req_valid_o, 1'b1);
        tick();
        mem_req_i = 1'b0; flush_i = 1'b1;
        #1;
        chk1("flush req stall", stall_o, 1'b1);
        tick();
        flush_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_quiet("flush req after");
            tick();
        end

        // Size 00 is not a request
        mem_req_i = 1'b1; sl_type_i = 4'b0000; addr_i = 32'h400;
        #1;
        chk1("nosize stall", stall_o, 1'b0);
        tick();
        check_quiet("nosize");
        mem_req_i = 1'b0;

        // Reset while waiting for a response
        mem_req_i = 1'b1; sl_type_i = 4'b0011; addr_i = 32'h500;
        tick();
        bus_req_ready_i = 1'b1;
        tick();
        bus_req_ready_i = 1'b0;
        #1;
        chk1("pre-rst rsp stall", stall_o, 1'b1);
        mem_req_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("rst mid rsp");
        chk32("rst rdata", rdata_o, 32'h0);
        chk32("rst addr",  bus_req_addr_o, 32'h0);
        chk1 ("rst we",    bus_req_we_o, 1'b0);
        run_txn("lw post rst", 4'b0011, 32'h600, 32'h0, 4'hF, 1, 1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
        mem_req_i = 1'b1; sl_type_i = 4'b0010; addr_i = 32'h101;
        #1;
        chk1("misal stall", stall_o, 1'b1);
        tick();
        chk1("misal pulse",   misalign_o, 1'b1);
        chk1("misal novalid", bus_req_valid_o, 1'b0);
        chk1("misal release", stall_o, 1'b0);
        chk1("misal rvalid",  rdata_valid_o, 1'b0);
        chk1("misal fault",   access_fault_o, 1'b0);
        mem_req_i = 1'b0;
        tick();
        check_quiet("misal after");
`else
        run_txn("lh 101", 4'b0010, 32'h101, 32'h0, 4'b0011, 0, 0, 1'b0, 32'h0000BEEF, 1'b0, 1'b0);
`endif

        // Randomized aligned traffic
        for (int n = 0; n < 24; n++) begin
            sz = 2'($urandom_range(1, 3));
            a  = $urandom;
            if (sz == 2'b10) a[0] = 1'b0;
            if (sz == 2'b11) a[1:0] = 2'b00;
            run_txn("rand", {1'($urandom), 1'($urandom), sz}, a, $urandom, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), $urandom, 1'b0, ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Sits directly downstream of the LoadStoreUnit in the MEM stage.
- Takes the LSU's lane-aligned store data and write strobes plus the access address, and runs a valid/ready request plus response transaction on the data-memory bus.
- Stalls the pipeline until the transaction completes, then returns the raw 32-bit read word, which feeds LoadStoreUnit load_data_i.
- Reports bus errors, response timeouts and (optionally) misaligned accesses.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in RSP before a timeout fault; range 1..255.
- TMO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req_i  in  1  MEM-stage instruction is a load or store
- sl_type_i  in  4  [3]=store, [2]=unsigned, [1:0]: 01 byte, 10 half, 11 word
- addr_i  in  32  byte address
- wdata_i  in  32  lane-aligned store data from the LSU
- wstrb_i  in  4  byte write enables from the LSU
- flush_i  in  1  kill the MEM-stage instruction
- stall_o  out  1  hold the pipeline
- rdata_o  out  32  raw read word, goes to LSU load_data_i
- rdata_valid_o  out  1  rdata_o valid this cycle
- access_fault_o  out  1  bus error or timeout, one-cycle pulse
- misalign_o  out  1  misaligned access, one-cycle pulse
- bus_req_valid_o  out  1  request valid
- bus_req_ready_i  in  1  request accepted
- bus_req_addr_o  out  32  {addr[31:2],2'b00}
- bus_req_we_o  out  1  write request
- bus_req_wstrb_o  out  4  write strobes; 4'b0000 on reads
- bus_req_wdata_o  out  32  write data
- bus_rsp_valid_i  in  1  response valid; the bus always accepts responses
- bus_rsp_rdata_i  in  32  read data
- bus_rsp_err_i  in  1  response error, qualified by bus_rsp_valid_i

Behaviour:
- States: IDLE, REQ, RSP, DONE.
- Reset:
  - state=IDLE, all outputs 0, timeout counter 0, drop flag 0.
  - Reset mid-transaction abandons it with no DONE cycle; the bus is expected to be reset in the same cycle.
- IDLE:
  - mem_req_i=1 and flush_i=0: register addr, we=sl_type_i[3], wstrb, wdata; go to REQ.
  - stall_o is asserted combinationally in this same cycle.
- REQ:
  - bus_req_valid_o=1; request fields are held stable from registers until the handshake.
  - valid&ready: go to RSP and clear the counter.
  - flush_i=1 before the handshake: drop valid and return to IDLE.
- RSP:
  - bus_rsp_valid_i=1: capture rdata (loads only) and the err flag; go to DONE.
  - Counter increments each cycle. Reaching TIMEOUT_CYCLES forces DONE with fault=1.
  - flush_i in RSP sets the drop flag; the response is still consumed.
- DONE:
  - stall_o=0 for exactly one cycle; the pipeline advances at the end of this cycle.
  - rdata_valid_o=1 for loads.
  - access_fault_o = err or timeout, only if drop=0.
  - With drop=1: no rdata_valid_o and no fault, and stall_o stays high through RSP so the flushed slot completes cleanly.
  - Next state is IDLE.
- Latency:
  - Minimum load/store = 3 stall cycles: IDLE detect, REQ with immediate ready, RSP with immediate response.
  - DONE is the release cycle.
- Stores also wait for a write response (ack).
- mem_req_i in IDLE with sl_type_i[1:0]=00 is treated as no request.
- rdata_o holds its last captured value outside DONE.
- A late response arriving after a timeout is ignored.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus request. It goes IDLE to DONE with misalign_o=1 for one cycle (one stall cycle total).
- Undefined: misalign_o is tied to 0, and misaligned accesses go to the bus unchanged using the LSU lane/strobe results.

Decomposition:
- Shared package holds:
  - dmem_state_e enum (IDLE, REQ, RSP, DONE).
  - sl_type bit-field constants: STORE_BIT=3, UNSIGNED_BIT=2, SIZE_B/H/W.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: dmem_timeout_cnt (clear, enable, expired).

Test Plan:
- LW addr 0x100, ready=1 immediately, response next cycle with rdata 0xDEADBEEF -> 3 stall cycles; DONE with rdata_o=0xDEADBEEF, rdata_valid_o=1, bus_req_addr_o=0x100, wstrb 0000.
- SB addr 0x203, wdata 0x55000000, wstrb 1000, ready delayed 4 cycles -> valid and all request fields stable for 4 cycles; we=1, addr 0x200; write ack ends with stall released for 1 cycle and rdata_valid_o=0.
- LW with response err=1 -> DONE with access_fault_o=1 pulse; no response ever, TIMEOUT_CYCLES=8 -> fault after 8 RSP cycles; a late response is then ignored.
- flush_i during REQ before ready -> valid drops, IDLE, no DONE pulse; flush_i during RSP -> response consumed, no rdata_valid_o and no fault.
- rst asserted in RSP -> next cycle all outputs 0 and state IDLE; a following LW completes normally.
- With DMEM_MISALIGN_CHECK_EN, LH addr 0x101 -> no bus_req_valid_o, misalign_o=1 in the DONE cycle after 1 stall cycle; without the macro -> normal bus read of 0x100.
